// File: rtl/tcb_vip_mem.sv
// Purpose: TCB subordinate VIP terminating a TCB bus with a byte-addressable memory model.
// Latency: a transfer occurs when vld & rdy; the response (rdt, err) follows one cycle later.
// Backpressure: rdy is held low for cfg_wait cycles before each non-locked transfer; locked follow-ons are served back-to-back.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   vld/rdy        request handshake (rdy depends on state only, never on vld)
//   wen, adr, ben  write enable, byte address (word aligned), byte enables
//   wdt            write data
//   lck, rpt       lock (back-to-back service request), repeat hint (ignored)
//   rdt, err       read data / error, valid in the response cycle
//   cfg_wait       wait states inserted before each non-locked transfer
//
// Optional feature: define TCB_VIP_MEM_ERR_EN to flag adr >= SIZE with err=1 and
// suppress the access; otherwise err stays 0 and the word index wraps into memory.
module tcb_vip_mem #(
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned SIZE = 4096,
    parameter int unsigned WW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vld,
    input  logic            wen,
    input  logic [AW-1:0]   adr,
    input  logic [DW/8-1:0] ben,
    input  logic [DW-1:0]   wdt,
    input  logic            lck,
    input  logic            rpt,
    output logic [DW-1:0]   rdt,
    output logic            err,
    output logic            rdy,
    input  logic [WW-1:0]   cfg_wait
);

    localparam int unsigned BW    = DW / 8;
    localparam int unsigned LB    = $clog2(BW);
    localparam int unsigned DEPTH = SIZE / BW;
    localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   cnt_q, cnt_d;
    logic            lck_hold;
    logic            xfer;
    logic            err_hit;
    logic [AW-1:0]   word;
    logic [IW-1:0]   idx;
    logic [DW-1:0]   bmask;
    logic [DW-1:0]   mem [DEPTH];

    // The repeat hint carries no meaning for a memory model.
    logic unused_rpt;
    assign unused_rpt = rpt;

    // Word index wraps modulo the memory depth; with the error check enabled,
    // wrapped indices are never used for an actual access.
    assign word = adr >> LB;
    assign idx  = IW'(word % AW'(DEPTH));

`ifdef TCB_VIP_MEM_ERR_EN
    assign err_hit = (adr >= AW'(SIZE));
`else
    assign err_hit = 1'b0;
`endif

    always_comb begin
        bmask = '0;
        for (int i = 0; i < int'(BW); i++) begin
            bmask[8*i +: 8] = {8{ben[i]}};
        end
    end

    // Next-state / ready. A wait count of w is realised as IDLE (1 cycle),
    // WAIT (w-2 .. 0, i.e. w-1 cycles ... minus the ACK) so that the transfer
    // lands exactly w cycles after vld is first seen.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdy     = 1'b0;
        case (state_q)
            IDLE: begin
                rdy = (cfg_wait == '0) | lck_hold;
                if (vld && !rdy) begin
                    if (cfg_wait == WW'(1)) begin
                        state_d = ACK;
                    end else begin
                        cnt_d   = cfg_wait - WW'(2);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = ACK;
                else             cnt_d   = cnt_q - WW'(1);
            end
            ACK: begin
                rdy     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // During reset the block looks like a freshly reset IDLE.
        if (rst) rdy = (cfg_wait == '0);
    end

    assign xfer = vld & rdy & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lck_hold <= 1'b0;
            rdt      <= '0;
            err      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err     <= xfer & err_hit;
            if (xfer) begin
                lck_hold <= lck;
                // Read data is sampled before this cycle's write lands.
                rdt      <= (wen || err_hit) ? '0 : (mem[idx] & bmask);
            end
        end
    end

    // Memory contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (xfer && wen && !err_hit) begin
            for (int i = 0; i < int'(BW); i++) begin
                if (ben[i]) mem[idx][8*i +: 8] <= wdt[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_tcb_vip_mem.sv
module tb_tcb_vip_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic        wen;
    logic [31:0] adr;
    logic [3:0]  ben;
    logic [31:0] wdt;
    logic        lck;
    logic        rpt;
    logic [31:0] rdt;
    logic        err;
    logic        rdy;
    logic [3:0]  cfg_wait;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tcb_vip_mem #(.AW(32), .DW(32), .SIZE(4096), .WW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .vld      (vld),
        .wen      (wen),
        .adr      (adr),
        .ben      (ben),
        .wdt      (wdt),
        .lck      (lck),
        .rpt      (rpt),
        .rdt      (rdt),
        .err      (err),
        .rdy      (rdy),
        .cfg_wait (cfg_wait)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, hold it until accepted, return wait count and response.
    task automatic do_xfer(input logic w, input logic [31:0] a, input logic [3:0] b,
                           input logic [31:0] d, input logic l,
                           output int waits, output logic [31:0] r, output logic e);
        vld = 1'b1; wen = w; adr = a; ben = b; wdt = d; lck = l;
        #1;
        waits = 0;
        while (!rdy && waits < 50) begin
            tick();
            waits++;
        end
        if (rdy) tick();
        vld = 1'b0;
        r   = rdt;
        e   = err;
    endtask

    int          wt;
    logic [31:0] r;
    logic        e;
    logic        exp_err;
    logic [31:0] exp_alias;

    initial begin
        rst = 1'b1; vld = 1'b0; wen = 1'b0; adr = '0; ben = '0; wdt = '0;
        lck = 1'b0; rpt = 1'b0; cfg_wait = 4'd0;
        tick();
        tick();
        check("rst_rdy_during", {31'd0, rdy}, 32'd1);
        rst = 1'b0;
        #1;
        check("reset_rdy", {31'd0, rdy}, 32'd1);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_rdt", rdt, 32'd0);

        // Zero-wait write then read
        do_xfer(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, wt, r, e);
        check("w0_waits", wt, 0);
        check("w0_err", {31'd0, e}, 32'd0);
        check("w0_rdt", r, 32'd0);
        do_xfer(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, wt, r, e);
        check("r0_waits", wt, 0);
        check("r0_rdt", r, 32'hDEADBEEF);

        // Byte enables
        do_xfer(1'b1, 32'h20, 4'hF, 32'hAAAAAAAA, 1'b0, wt, r, e);
        do_xfer(1'b1, 32'h20, 4'b0101, 32'h11223344, 1'b0, wt, r, e);
        do_xfer(1'b0, 32'h20, 4'hF, 32'h0, 1'b0, wt, r, e);
        check("ben_full", r, 32'hAA22AA44);
        do_xfer(1'b0, 32'h20, 4'b0011, 32'h0, 1'b0, wt, r, e);
        check("ben_low", r, 32'h0000AA44);
        tick();
        check("rdt_hold", rdt, 32'h0000AA44);
        check("err_idle", {31'd0, err}, 32'd0);

        // Wait states: back-to-back requests each see the full wait count
        cfg_wait = 4'd3;
        do_xfer(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, wt, r, e);
        check("w3_waits", wt, 3);
        check("w3_rdt", r, 32'hDEADBEEF);
        do_xfer(1'b0, 32'h20, 4'hF, 32'h0, 1'b0, wt, r, e);
        check("w3_again", wt, 3);
        check("w3_rdt2", r, 32'hAA22AA44);
        cfg_wait = 4'd1;
        do_xfer(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, wt, r, e);
        check("w1_waits", wt, 1);

        // cfg_wait changes while waiting are ignored
        cfg_wait = 4'd4;
        vld = 1'b1; wen = 1'b0; adr = 32'h20; ben = 4'hF; lck = 1'b0;
        #1;
        tick();
        cfg_wait = 4'd0;
        #1;
        wt = 1;
        while (!rdy && wt < 50) begin
            tick();
            wt++;
        end
        check("cfg_chg_waits", wt, 4);
        tick();
        vld = 1'b0;
        check("cfg_chg_rdt", rdt, 32'hAA22AA44);

        // Lock burst
        cfg_wait = 4'd2;
        do_xfer(1'b0, 32'h10, 4'hF, 32'h0, 1'b1, wt, r, e);
        check("lck1_waits", wt, 2);
        do_xfer(1'b0, 32'h20, 4'hF, 32'h0, 1'b1, wt, r, e);
        check("lck2_waits", wt, 0);
        check("lck2_rdt", r, 32'hAA22AA44);
        do_xfer(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, wt, r, e);
        check("lck3_waits", wt, 0);
        check("lck3_rdt", r, 32'hDEADBEEF);
        do_xfer(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, wt, r, e);
        check("unlck_waits", wt, 2);

        // Out-of-range access
        cfg_wait = 4'd0;
`ifdef TCB_VIP_MEM_ERR_EN
        exp_err   = 1'b1;
        exp_alias = 32'h12345678;
`else
        exp_err   = 1'b0;
        exp_alias = 32'hCAFEF00D;
`endif
        do_xfer(1'b1, 32'h0, 4'hF, 32'h12345678, 1'b0, wt, r, e);
        do_xfer(1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 1'b0, wt, r, e);
        check("oor_err", {31'd0, e}, {31'd0, exp_err});
        check("oor_rdt", r, 32'd0);
        tick();
        check("oor_err_clr", {31'd0, err}, 32'd0);
        do_xfer(1'b0, 32'h0, 4'hF, 32'h0, 1'b0, wt, r, e);
        check("oor_mem0", r, exp_alias);
        check("oor_rd_err", {31'd0, e}, 32'd0);

        // Reset in the middle of a wait
        cfg_wait = 4'd5;
        vld = 1'b1; wen = 1'b0; adr = 32'h10; ben = 4'hF; lck = 1'b0;
        #1;
        check("w5_rdy", {31'd0, rdy}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_mid_rdy", {31'd0, rdy}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_rdy", {31'd0, rdy}, 32'd0);
        check("post_rst_err", {31'd0, err}, 32'd0);
        check("post_rst_rdt", rdt, 32'd0);
        vld = 1'b0;
        cfg_wait = 4'd0;
        #1;
        check("post_rst_idle", {31'd0, rdy}, 32'd1);
        do_xfer(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, wt, r, e);
        check("post_rst_data", r, 32'hDEADBEEF);
        check("post_rst_waits", wt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
